// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator SCAN controller.
//   MOTOR_STOP / MOTOR_DOWN / MOTOR_UP : motor command encoding
//   state_e                            : controller FSM states
//   DIR_UP / DIR_DOWN                  : encoding of the direction bit
//   motor_for()                        : motor command for a travel direction
package elevator_pkg;

  localparam logic [1:0] MOTOR_STOP = 2'b00;
  localparam logic [1:0] MOTOR_DOWN = 2'b01;
  localparam logic [1:0] MOTOR_UP   = 2'b10;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_e;

  // Motor command that drives the car in direction d.
  function automatic logic [1:0] motor_for(input logic d);
    return (d == DIR_UP) ? MOTOR_UP : MOTOR_DOWN;
  endfunction

endpackage

// File: rtl/elevator_req_scan.sv
// Combinational call scanner for the elevator controller.
// Ports:
//   pending   in  N_FLOORS  latched call bitmap
//   floor     in  FW        floor the decision is made for
//   dir       in  1         current direction bit (tie-break)
//   any_above out 1         some call strictly above floor
//   any_below out 1         some call strictly below floor
//   near_up   out 1         nearest call lies above (ties resolved toward dir)
module elevator_req_scan
  import elevator_pkg::*;
#(
  parameter int unsigned N_FLOORS = 8,
  parameter int unsigned FW       = $clog2(N_FLOORS)
) (
  input  logic [N_FLOORS-1:0] pending,
  input  logic [FW-1:0]       floor,
  input  logic                dir,
  output logic                any_above,
  output logic                any_below,
  output logic                near_up
);

  // One extra bit so a "no call" distance of N_FLOORS is representable.
  localparam int unsigned DW = FW + 1;

  logic [DW-1:0] dist_up;
  logic [DW-1:0] dist_dn;

  // Ascending scan: first hit above is the nearest above, last hit below is
  // the nearest below.
  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    dist_up   = DW'(N_FLOORS);
    dist_dn   = DW'(N_FLOORS);
    for (int i = 0; i < int'(N_FLOORS); i++) begin
      if (pending[i] && (DW'(i) > DW'(floor)) && !any_above) begin
        any_above = 1'b1;
        dist_up   = DW'(i) - DW'(floor);
      end
      if (pending[i] && (DW'(i) < DW'(floor))) begin
        any_below = 1'b1;
        dist_dn   = DW'(floor) - DW'(i);
      end
    end
  end

  // Equal distances go the way the car last travelled.
  always_comb begin
    near_up = any_above &&
              (!any_below || (dist_up < dist_dn) ||
               ((dist_up == dist_dn) && (dir == DIR_UP)));
  end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// Single-car elevator controller using SCAN scheduling.
// Ports:
//   clk        in  1         rising-edge clock
//   reset      in  1         asynchronous active-high reset
//   req        in  N_FLOORS  floor-call buttons (any pulse width)
//   motor      out 2         00 stop, 01 down, 10 up
//   floor      out FW        current floor, 0 = bottom
//   door_open  out 1         door is open
//   pending    out N_FLOORS  latched, unserved calls
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int unsigned N_FLOORS   = 8,
  parameter int unsigned TRAVEL_CYC = 4,
  parameter int unsigned DOOR_CYC   = 3,
  parameter int unsigned FW         = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] req,
  output logic [1:0]          motor,
  output logic [FW-1:0]       floor,
  output logic                door_open,
  output logic [N_FLOORS-1:0] pending
);

  localparam int unsigned CNT_MAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_CYC - 1);
  localparam logic [CW-1:0] DOOR_LAST   = CW'(DOOR_CYC - 1);

  state_e              state;
  state_e              state_nxt;
  logic                dir;
  logic                dir_nxt;
  logic [FW-1:0]       floor_nxt;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_nxt;
  logic [N_FLOORS-1:0] pending_nxt;
  logic [1:0]          motor_nxt;
  logic                door_nxt;

  logic                arrive;
  logic [FW-1:0]       look_floor;
  logic                any_above;
  logic                any_below;
  logic                near_up;
  logic                ahead;
  logic                behind;
  logic                call_here;

  // Last cycle of a one-floor travel step.
  assign arrive = (state == ST_MOVE) && (cnt == TRAVEL_LAST);

  // Decisions on arrival are made for the floor being reached, not the one left.
  assign look_floor = !arrive        ? floor :
                      (dir == DIR_UP) ? floor + FW'(1) : floor - FW'(1);

  elevator_req_scan #(
    .N_FLOORS (N_FLOORS),
    .FW       (FW)
  ) u_scan (
    .pending   (pending),
    .floor     (look_floor),
    .dir       (dir),
    .any_above (any_above),
    .any_below (any_below),
    .near_up   (near_up)
  );

  assign ahead     = (dir == DIR_UP) ? any_above : any_below;
  assign behind    = (dir == DIR_UP) ? any_below : any_above;
  assign call_here = pending[look_floor];

  // State, floor and outputs register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      dir       <= DIR_UP;
      floor     <= '0;
      cnt       <= '0;
      pending   <= '0;
      motor     <= MOTOR_STOP;
      door_open <= 1'b0;
    end else begin
      state     <= state_nxt;
      dir       <= dir_nxt;
      floor     <= floor_nxt;
      cnt       <= cnt_nxt;
      pending   <= pending_nxt;
      motor     <= motor_nxt;
      door_open <= door_nxt;
    end
  end

  // Next-state, counter, call latch and output decode.
  always_comb begin
    state_nxt   = state;
    dir_nxt     = dir;
    floor_nxt   = floor;
    cnt_nxt     = cnt;
    motor_nxt   = MOTOR_STOP;
    door_nxt    = 1'b0;
    pending_nxt = pending | req;

    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (call_here) begin
          state_nxt = ST_DOOR;
        end else if (any_above || any_below) begin
          state_nxt = ST_MOVE;
          dir_nxt   = near_up ? DIR_UP : DIR_DOWN;
        end
      end

      ST_MOVE: begin
        if (arrive) begin
          floor_nxt = look_floor;
          cnt_nxt   = '0;
          if (call_here) begin
            state_nxt = ST_DOOR;
          end else if (!ahead) begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      ST_DOOR: begin
        // A call at this floor holds the door rather than queuing.
        if (req[floor]) begin
          cnt_nxt = '0;
        end else if (cnt == DOOR_LAST) begin
          cnt_nxt = '0;
          if (ahead) begin
            state_nxt = ST_MOVE;
          end else if (behind) begin
            state_nxt = ST_MOVE;
            dir_nxt   = ~dir;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    if (state == ST_DOOR) begin
      pending_nxt[floor] = 1'b0;
    end
    if (state_nxt == ST_DOOR) begin
      pending_nxt[floor_nxt] = 1'b0;
    end

    // Motor and door are mutually exclusive by construction of state_nxt.
    if (state_nxt == ST_MOVE) begin
      motor_nxt = motor_for(dir_nxt);
    end
    door_nxt = (state_nxt == ST_DOOR);
  end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Self-checking bench for elevator_scan_ctrl (8 floors, 4-cycle travel,
// 3-cycle door). A cycle-level behavioural model predicts the outputs after
// every clock edge; predictions go into a queue that a monitor drains.
module tb_elevator_scan_ctrl;

  localparam int NF = 8;
  localparam int TC = 4;
  localparam int DC = 3;

  localparam int M_IDLE   = 0;
  localparam int M_TRAVEL = 1;
  localparam int M_DOOR   = 2;

  typedef struct packed {
    logic [1:0] motor;
    logic [2:0] floor;
    logic       door;
    logic [7:0] pend;
  } snap_t;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [1:0] motor;
  logic [2:0] floor;
  logic       door_open;
  logic [7:0] pending;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  snap_t exp_q[$];

  // Reference model state: plain integers and a call bitmap.
  int       m_floor;
  bit       m_up;
  bit [7:0] m_pend;
  int       m_left;
  int       m_mode;

  elevator_scan_ctrl #(
    .N_FLOORS   (NF),
    .TRAVEL_CYC (TC),
    .DOOR_CYC   (DC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .motor     (motor),
    .floor     (floor),
    .door_open (door_open),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    n_assert++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic int near_above(input int f, input bit [7:0] p);
    for (int i = f + 1; i < NF; i++) if (p[i]) return i;
    return -1;
  endfunction

  function automatic int near_below(input int f, input bit [7:0] p);
    for (int i = f - 1; i >= 0; i--) if (p[i]) return i;
    return -1;
  endfunction

  function automatic bit has_ahead(input int f, input bit up, input bit [7:0] p);
    return up ? (near_above(f, p) >= 0) : (near_below(f, p) >= 0);
  endfunction

  task automatic model_reset();
    m_floor = 0;
    m_up    = 1'b1;
    m_pend  = '0;
    m_left  = 0;
    m_mode  = M_IDLE;
  endtask

  // Advance the model across one clock edge with buttons r, push prediction.
  task automatic model_step(input bit [7:0] r);
    bit [7:0] p;
    int       a;
    int       b;
    int       old_mode;
    int       old_floor;
    snap_t    s;
    p         = m_pend;
    old_mode  = m_mode;
    old_floor = m_floor;
    if (m_mode == M_IDLE) begin
      a = near_above(m_floor, p);
      b = near_below(m_floor, p);
      if (p[m_floor]) begin
        m_mode = M_DOOR; m_left = DC;
      end else if (a >= 0 || b >= 0) begin
        if (a < 0) m_up = 1'b0;
        else if (b < 0) m_up = 1'b1;
        else if ((a - m_floor) < (m_floor - b)) m_up = 1'b1;
        else if ((a - m_floor) > (m_floor - b)) m_up = 1'b0;
        m_mode = M_TRAVEL; m_left = TC;
      end
    end else if (m_mode == M_TRAVEL) begin
      m_left--;
      if (m_left == 0) begin
        m_floor = m_up ? m_floor + 1 : m_floor - 1;
        if (p[m_floor]) begin
          m_mode = M_DOOR; m_left = DC;
        end else if (has_ahead(m_floor, m_up, p)) begin
          m_left = TC;
        end else begin
          m_mode = M_IDLE;
        end
      end
    end else begin
      if (r[m_floor]) begin
        m_left = DC;
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (has_ahead(m_floor, m_up, p)) begin
            m_mode = M_TRAVEL; m_left = TC;
          end else if (has_ahead(m_floor, !m_up, p)) begin
            m_up = !m_up; m_mode = M_TRAVEL; m_left = TC;
          end else begin
            m_mode = M_IDLE;
          end
        end
      end
    end
    m_pend = p | r;
    if (old_mode == M_DOOR) m_pend[old_floor] = 1'b0;
    if (m_mode == M_DOOR) m_pend[m_floor] = 1'b0;
    s.motor = (m_mode == M_TRAVEL) ? (m_up ? 2'b10 : 2'b01) : 2'b00;
    s.floor = 3'(m_floor);
    s.door  = (m_mode == M_DOOR);
    s.pend  = m_pend;
    exp_q.push_back(s);
  endtask

  // Drive one cycle of buttons; returns shortly after the sampling edge.
  task automatic step(input bit [7:0] r);
    @(negedge clk);
    req = r;
    model_step(r);
    @(posedge clk);
    #3;
  endtask

  // Asynchronous reset asserted between clock edges, checked at once.
  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    req   = '0;
    #1;
    chk("reset motor", int'(motor), 0);
    chk("reset floor", int'(floor), 0);
    chk("reset door", int'(door_open), 0);
    chk("reset pending", int'(pending), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    model_step('0);
    @(posedge clk);
    #3;
  endtask

  task automatic wait_door(input int max_cyc);
    int k;
    k = 0;
    while (!door_open && k < max_cyc) begin
      step('0);
      k++;
    end
    chk("wait door_open", int'(door_open), 1);
  endtask

  task automatic wait_closed(input int max_cyc);
    int k;
    k = 0;
    while (door_open && k < max_cyc) begin
      step('0);
      k++;
    end
    chk("wait door closed", int'(door_open), 0);
  endtask

  task automatic wait_floor(input int f, input int max_cyc);
    int k;
    k = 0;
    while (int'(floor) != f && k < max_cyc) begin
      step('0);
      k++;
    end
    chk("wait floor", int'(floor), f);
  endtask

  // Monitor: compares the DUT against each queued prediction after its edge.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      chk($sformatf("cyc%0d door with motor", cyc), int'(door_open && (motor != 2'b00)), 0);
      chk($sformatf("cyc%0d motor code", cyc), int'(motor == 2'b11), 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk($sformatf("cyc%0d motor", cyc), int'(motor), int'(e.motor));
        chk($sformatf("cyc%0d floor", cyc), int'(floor), int'(e.floor));
        chk($sformatf("cyc%0d door_open", cyc), int'(door_open), int'(e.door));
        chk($sformatf("cyc%0d pending", cyc), int'(pending), int'(e.pend));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [7:0] r;
    reset = 1'b0;
    req   = '0;
    model_reset();

    // Call to floor 3 from rest at 0.
    do_reset();
    step(8'h08);
    chk("s29 pending latched", int'(pending[3]), 1);
    step('0);
    chk("s29 motor up", int'(motor), 2);
    chk("s29 still at 0", int'(floor), 0);
    repeat (4) step('0);
    chk("s29 floor 1", int'(floor), 1);
    repeat (4) step('0);
    chk("s29 floor 2", int'(floor), 2);
    repeat (4) step('0);
    chk("s29 floor 3", int'(floor), 3);
    chk("s29 door at 3", int'(door_open), 1);
    chk("s29 motor stop at 3", int'(motor), 0);
    chk("s29 pending3 cleared", int'(pending[3]), 0);
    repeat (2) step('0);
    chk("s29 door third cycle", int'(door_open), 1);
    step('0);
    chk("s29 door closed", int'(door_open), 0);
    chk("s29 idle motor", int'(motor), 0);

    // Call at the current floor: door only.
    do_reset();
    step(8'h01);
    step('0);
    chk("s30 door", int'(door_open), 1);
    chk("s30 motor", int'(motor), 0);
    repeat (2) step('0);
    chk("s30 door held", int'(door_open), 1);
    chk("s30 floor", int'(floor), 0);
    step('0);
    chk("s30 door closed", int'(door_open), 0);

    // Call behind the car does not preempt upward travel.
    do_reset();
    step(8'h40);
    wait_floor(2, 40);
    step(8'h02);
    wait_door(60);
    chk("s31 first stop", int'(floor), 6);
    wait_closed(20);
    chk("s31 reverse down", int'(motor), 1);
    wait_door(60);
    chk("s31 second stop", int'(floor), 1);

    // Equidistant calls from floor 3 with dir up.
    do_reset();
    step(8'h08);
    wait_door(40);
    chk("s32 at 3", int'(floor), 3);
    wait_closed(20);
    step(8'h22);
    wait_door(40);
    chk("s32 tie goes up", int'(floor), 5);
    wait_closed(20);
    chk("s32 then down", int'(motor), 1);
    wait_door(60);
    chk("s32 then 1", int'(floor), 1);

    // Reset two cycles into a travel step.
    do_reset();
    step(8'h20);
    wait_floor(2, 40);
    step(8'h80);
    step('0);
    chk("s33 moving", int'(motor), 2);
    chk("s33 pending set", int'(pending != 0), 1);
    do_reset();

    // Door hold at floor 4.
    step(8'h10);
    wait_door(40);
    chk("s34 at 4", int'(floor), 4);
    step('0);
    step(8'h10);
    chk("s34 door after pulse", int'(door_open), 1);
    chk("s34 pending4 stays 0", int'(pending[4]), 0);
    step('0);
    step('0);
    chk("s34 door extended", int'(door_open), 1);
    chk("s34 pending4 still 0", int'(pending[4]), 0);
    step('0);
    chk("s34 door closed", int'(door_open), 0);

    // Random button traffic against the model, with occasional resets.
    for (int i = 0; i < 2400; i++) begin
      if (i == 800 || i == 1600) do_reset();
      r = '0;
      if ($urandom_range(0, 7) == 0) r[$urandom_range(0, 7)] = 1'b1;
      if ($urandom_range(0, 31) == 0) r[$urandom_range(0, 7)] = 1'b1;
      step(r);
    end
    repeat (2) step('0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
